// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared 7-segment glyph table and output polarity helper
package led_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Converts an active-high pattern to the pin level for the board's drive polarity.
  function automatic logic [7:0] apply_pol(input logic [7:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-high 7-segment glyph
module seg7_decode
  import led_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_GLYPH[nibble_i];

endmodule

// File: rtl/led_hex_mux.sv
// rtl/led_hex_mux.sv - multiplexed hex display driver with double buffering, PWM and blanking
module led_hex_mux
  import led_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int DIV_BITS         = 12,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic                  pending,
  output logic                  frame,
  output logic [7:0]            led_c,
  output logic [DIGITS-1:0]     led_a
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

  logic [DIV_BITS-1:0] slot_q, slot_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [4*DIGITS-1:0] disp_num_q, disp_num_d, pend_num_q, pend_num_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                pending_q, pending_d, frame_q, frame_d, lz_run_q, lz_run_d;
  logic [7:0]          led_c_q, led_c_d;
  logic [DIGITS-1:0]   led_a_q, led_a_d;

  logic                slot_wrap, boundary, anode_on, blank, cur_dp;
  logic [3:0]          cur_nibble, sub;
  logic [6:0]          glyph, seg_lit;
  logic [DIGITS-1:0]   anode_raw;

  seg7_decode u_decode (
    .nibble_i (cur_nibble),
    .seg_o    (glyph)
  );

  // Scan counters, tear-free buffering, blanking state and registered pin drive.
  always_comb begin
    slot_wrap  = &slot_q;
    boundary   = slot_wrap && (digit_q == LAST_DIGIT);
    sub        = slot_q[DIV_BITS-1 -: 4];
    anode_on   = (sub <= brightness);

    cur_nibble = 4'd0;
    cur_dp     = 1'b0;
    anode_raw  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_q == DW'(k)) begin
        cur_nibble   = disp_num_q[4*(DIGITS-k)-1 -: 4];
        cur_dp       = disp_dp_q[DIGITS-1-k];
        anode_raw[k] = anode_on;
      end
    end

    // Blank only zeros that precede the first nonzero digit; the last digit always shows.
    blank   = blank_lz && lz_run_q && (cur_nibble == 4'd0) && (digit_q != LAST_DIGIT);
    seg_lit = blank ? 7'd0 : glyph;

    slot_d  = slot_q + DIV_BITS'(1);
    digit_d = digit_q;
    if (slot_wrap) begin
      digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DW'(1);
    end

    lz_run_d = lz_run_q;
    if (boundary) begin
      lz_run_d = 1'b1;
    end else if (slot_wrap && (cur_nibble != 4'd0)) begin
      lz_run_d = 1'b0;
    end

    pend_num_d = pend_num_q;
    pend_dp_d  = pend_dp_q;
    disp_num_d = disp_num_q;
    disp_dp_d  = disp_dp_q;
    pending_d  = pending_q;
    if (load) begin
      pend_num_d = number;
      pend_dp_d  = dp;
    end
    if (boundary) begin
      // A load landing on the boundary itself bypasses the pending stage.
      pending_d = 1'b0;
      if (load) begin
        disp_num_d = number;
        disp_dp_d  = dp;
      end else if (pending_q) begin
        disp_num_d = pend_num_q;
        disp_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end

    frame_d = boundary;
    led_c_d = apply_pol({cur_dp, seg_lit}, SEG_ACTIVE_LOW);
    led_a_d = ANODE_ACTIVE_LOW ? ~anode_raw : anode_raw;
  end

  // State register; reset drops every output to its inactive level and discards any pending update.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      slot_q     <= '0;
      digit_q    <= '0;
      disp_num_q <= '0;
      disp_dp_q  <= '0;
      pend_num_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      frame_q    <= 1'b0;
      lz_run_q   <= 1'b1;
      led_c_q    <= apply_pol(8'h00, SEG_ACTIVE_LOW);
      led_a_q    <= ANODE_OFF;
    end else begin
      slot_q     <= slot_d;
      digit_q    <= digit_d;
      disp_num_q <= disp_num_d;
      disp_dp_q  <= disp_dp_d;
      pend_num_q <= pend_num_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
      lz_run_q   <= lz_run_d;
      led_c_q    <= led_c_d;
      led_a_q    <= led_a_d;
    end
  end

  assign pending = pending_q;
  assign frame   = frame_q;
  assign led_c   = led_c_q;
  assign led_a   = led_a_q;

endmodule
